// File: rtl/regbus_pkg.sv
// Shared types and default widths for the register-bus initiator.
package regbus_pkg;

  localparam int ADDR_WIDTH_DEF = 8;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int TMO_WIDTH_DEF  = 8;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_RMW   = 2'b10,
    OP_POLL  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ERR_OK           = 2'b00,
    ERR_NO_VALID     = 2'b01,
    ERR_POLL_TIMEOUT = 2'b10
  } err_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_GAP  = 3'd3,
    ST_RESP = 3'd4
  } state_e;

endpackage

// File: rtl/regbus_poll_ctr.sv
// Read counter for POLL: loadable limit (0 becomes 1), clear, saturating increment.
module regbus_poll_ctr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] limit,
  input  logic         inc,
  output logic         hit,
  output logic         last
);

  logic [W-1:0] count;
  logic [W-1:0] limit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      limit_q <= '0;
    end else begin
      if (load) limit_q <= (limit == '0) ? W'(1) : limit;
      if (clr) count <= '0;
      else if (inc && !hit) count <= count + W'(1);
    end
  end

  assign hit  = (count == limit_q);
  // True while the read in progress is the one that reaches the limit.
  assign last = (({1'b0, count} + (W+1)'(1)) == {1'b0, limit_q});

endmodule

// File: rtl/regbus_master.sv
// Single-command register-bus initiator: WRITE, READ, RMW and POLL with timeout.
module regbus_master
  import regbus_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TMO_WIDTH  = TMO_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_mask,
  input  logic [TMO_WIDTH-1:0]  req_limit,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_err,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  chip_select,
  output logic                  write_en,
  output logic                  read_en,
  output logic [DATA_WIDTH-1:0] write_data,
  input  logic [DATA_WIDTH-1:0] read_data,
  input  logic                  data_valid,
  output logic [2:0]            state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid and its payload hold until that edge.
  state_e                state;
  op_e                   op_q;
  err_e                  err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] mask_q;
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  accept;
  logic                  poll_match;
  logic                  ctr_hit;
  logic                  ctr_last;

  assign accept     = (state == ST_IDLE) && req_valid;
  assign poll_match = ((read_data ^ wdata_q) & mask_q) == '0;

  regbus_poll_ctr #(.W(TMO_WIDTH)) u_poll_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .load  (accept),
    .limit (req_limit),
    .inc   (state == ST_RD),
    .hit   (ctr_hit),
    .last  (ctr_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      op_q    <= OP_WRITE;
      err_q   <= ERR_OK;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      rd_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: if (req_valid) begin
          op_q    <= op_e'(req_op);
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          mask_q  <= req_mask;
          rd_q    <= '0;
          err_q   <= ERR_OK;
          state   <= (op_e'(req_op) == OP_WRITE) ? ST_WR : ST_RD;
        end
        ST_RD: begin
          if (!data_valid) begin
            rd_q  <= '0;
            err_q <= ERR_NO_VALID;
            state <= ST_RESP;
          end else begin
            rd_q <= read_data;
            case (op_q)
              OP_RMW:  state <= ST_WR;
              OP_POLL: begin
                if (poll_match) state <= ST_RESP;
                else if (ctr_last || ctr_hit) begin
                  err_q <= ERR_POLL_TIMEOUT;
                  state <= ST_RESP;
                end else state <= ST_GAP;
              end
              default: state <= ST_RESP;
            endcase
          end
        end
        ST_WR:   state <= ST_RESP;
        ST_GAP:  state <= ST_RD;
        ST_RESP: if (rsp_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Bus drive depends only on state and latched request fields.
  assign chip_select = (state == ST_RD) || (state == ST_WR);
  assign write_en    = (state == ST_WR);
  assign read_en     = (state == ST_RD);
  assign addr        = (state == ST_IDLE) ? '0 : addr_q;
  assign write_data  = (state == ST_IDLE) ? '0 :
                       (op_q == OP_RMW) ? ((rd_q & ~mask_q) | (wdata_q & mask_q)) : wdata_q;

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign rsp_rdata = rsp_valid ? rd_q : '0;
  assign rsp_err   = rsp_valid ? err_q : ERR_OK;
  assign state_dbg = state;

endmodule
